// File: rtl/seq_udiv_ctrl_pkg.sv
// Shared types and constants for the sequential restoring unsigned divider.
package seq_udiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_N = 4;

  // Quotient reported for a zero divisor: all ones at width n (n <= 32).
  function automatic logic [31:0] div0_quot(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/seq_udiv_ctrl_sub.sv
// W-bit A-B with carry-in 1 on the carry chain; cout_o=1 means a_i >= b_i (unsigned).
module udiv_sub_cout #(
  parameter int W = 5
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         cout_o
);

  logic [W:0] sum;

  assign sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
  assign diff_o = sum[W-1:0];
  assign cout_o = sum[W];

endmodule

// File: rtl/seq_udiv_ctrl.sv
// Restoring unsigned divider controller: one quotient bit per cycle through a
// single shared subtractor, valid/ready on both request and result sides.
module seq_udiv_ctrl
  import seq_udiv_ctrl_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         CLK,
  input  logic         ASYNCRESETN,
  input  logic         I_VALID,
  output logic         I_READY,
  input  logic [N-1:0] I_DIVIDEND,
  input  logic [N-1:0] I_DIVISOR,
  output logic         O_VALID,
  input  logic         O_READY,
  output logic [N-1:0] O_QUOTIENT,
  output logic [N-1:0] O_REMAINDER,
  output logic         O_DIV0
);

  localparam int             CW      = $clog2(N);
  localparam logic [31:0]    Q0_FULL = div0_quot(N);
  localparam logic [N-1:0]   Q_DIV0  = Q0_FULL[N-1:0];
  localparam logic [CW-1:0]  LAST    = CW'(N - 1);

  state_t          state_q, state_d;
  logic [N-1:0]    d_q, d_d, q_q, q_d;
  logic [N:0]      r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    oq_q, oq_d, or_q, or_d;
  logic            od_q, od_d;

  logic [N:0]      t, diff, r_step;
  logic [N-1:0]    q_step;
  logic            cout;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign t = {r_q[N-1:0], q_q[N-1]};

  udiv_sub_cout #(.W(N + 1)) u_sub (
    .a_i    (t),
    .b_i    ({1'b0, d_q}),
    .diff_o (diff),
    .cout_o (cout)
  );

  assign r_step = cout ? diff : t;
  assign q_step = {q_q[N-2:0], cout};

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    oq_d    = oq_q;
    or_d    = or_q;
    od_d    = od_q;
    case (state_q)
      ST_IDLE: if (I_VALID) begin
        d_d   = I_DIVISOR;
        q_d   = I_DIVIDEND;
        r_d   = '0;
        cnt_d = '0;
        if (I_DIVISOR == '0) begin
          state_d = ST_DONE;
          oq_d    = Q_DIV0;
          or_d    = I_DIVIDEND;
          od_d    = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        r_d = r_step;
        q_d = q_step;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          oq_d    = q_step;
          or_d    = r_step[N-1:0];
          od_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: if (O_READY) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      oq_q    <= '0;
      or_q    <= '0;
      od_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      oq_q    <= oq_d;
      or_q    <= or_d;
      od_q    <= od_d;
    end
  end

  assign I_READY     = (state_q == ST_IDLE);
  assign O_VALID     = (state_q == ST_DONE);
  assign O_QUOTIENT  = oq_q;
  assign O_REMAINDER = or_q;
  assign O_DIV0      = od_q;

endmodule

// File: tb/tb_seq_udiv_ctrl.sv
// Bench for seq_udiv_ctrl: directed N=4 scenarios plus an N=8 randomized sweep
// against plain / and % arithmetic.
module tb_seq_udiv_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=4 instance
  logic       rst4_n, iv4, ir4, ov4, ordy4, od4;
  logic [3:0] dd4, ds4, oq4, orm4;
  // N=8 instance
  logic       rst8_n, iv8, ir8, ov8, ordy8, od8;
  logic [7:0] dd8, ds8, oq8, orm8;

  seq_udiv_ctrl #(.N(4)) u4 (
    .CLK(clk), .ASYNCRESETN(rst4_n), .I_VALID(iv4), .I_READY(ir4),
    .I_DIVIDEND(dd4), .I_DIVISOR(ds4), .O_VALID(ov4), .O_READY(ordy4),
    .O_QUOTIENT(oq4), .O_REMAINDER(orm4), .O_DIV0(od4)
  );

  seq_udiv_ctrl #(.N(8)) u8 (
    .CLK(clk), .ASYNCRESETN(rst8_n), .I_VALID(iv8), .I_READY(ir8),
    .I_DIVIDEND(dd8), .I_DIVISOR(ds8), .O_VALID(ov8), .O_READY(ordy8),
    .O_QUOTIENT(oq8), .O_REMAINDER(orm8), .O_DIV0(od8)
  );

  // Issue one N=4 request, count edges from the accept edge until O_VALID,
  // capture the result and complete the result handshake.
  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     output logic [3:0] q, output logic [3:0] r,
                     output logic d0, output int lat);
    int t;
    @(negedge clk);
    iv4 = 1'b1; dd4 = a; ds4 = b;
    t = 0;
    while (!ir4 && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1 iv4 = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!ov4 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    q = oq4; r = orm4; d0 = od4;
    ordy4 = 1'b1;
    @(posedge clk); #1 ordy4 = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL reset_i_ready got %b exp 1", ir4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b exp 0", ov4); end
    checks++; if (oq4 !== 4'h0) begin errors++; $display("FAIL reset_quot got %h exp 0", oq4); end
    checks++; if (orm4 !== 4'h0) begin errors++; $display("FAIL reset_rem got %h exp 0", orm4); end
    checks++; if (od4 !== 1'b0) begin errors++; $display("FAIL reset_div0 got %b exp 0", od4); end
  endtask

  task automatic test_directed;
    logic [3:0] ta [6] = '{4'd13, 4'd15, 4'd0, 4'd3, 4'd15, 4'd7};
    logic [3:0] tb [6] = '{4'd3,  4'd1,  4'd7, 4'd15, 4'd15, 4'd0};
    logic [3:0] q, r, eq, er;
    logic d0, ed0;
    int lat, elat;
    for (int i = 0; i < 6; i++) begin
      op4(ta[i], tb[i], q, r, d0, lat);
      if (tb[i] == 0) begin eq = 4'hF; er = ta[i]; ed0 = 1'b1; elat = 1; end
      else begin eq = ta[i] / tb[i]; er = ta[i] % tb[i]; ed0 = 1'b0; elat = 5; end
      checks++; if (q !== eq) begin errors++; $display("FAIL dir_quot %0d/%0d got %0d exp %0d", ta[i], tb[i], q, eq); end
      checks++; if (r !== er) begin errors++; $display("FAIL dir_rem %0d/%0d got %0d exp %0d", ta[i], tb[i], r, er); end
      checks++; if (d0 !== ed0) begin errors++; $display("FAIL dir_div0 %0d/%0d got %b exp %b", ta[i], tb[i], d0, ed0); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL dir_latency %0d/%0d got %0d exp %0d", ta[i], tb[i], lat, elat); end
      @(negedge clk);
      checks++; if (ir4 !== 1'b1 || ov4 !== 1'b0) begin errors++; $display("FAIL dir_back_idle %0d/%0d got rdy %b vld %b exp rdy 1 vld 0", ta[i], tb[i], ir4, ov4); end
    end
  endtask

  task automatic test_stall;
    int t;
    @(negedge clk);
    iv4 = 1'b1; dd4 = 4'd9; ds4 = 4'd2;
    t = 0;
    while (!ir4 && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1 iv4 = 1'b0;
    t = 0;
    @(negedge clk);
    while (!ov4 && t < 50) begin @(negedge clk); t++; end
    checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL stall_reach_done got %b exp 1", ov4); end
    iv4 = 1'b1; dd4 = 4'd5; ds4 = 4'd1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b exp 1", c, ov4); end
      checks++; if (oq4 !== 4'd4 || orm4 !== 4'd1) begin errors++; $display("FAIL stall_data cyc %0d got q %0d r %0d exp q 4 r 1", c, oq4, orm4); end
      checks++; if (ir4 !== 1'b0) begin errors++; $display("FAIL stall_i_ready cyc %0d got %b exp 0", c, ir4); end
    end
    iv4 = 1'b0;
    ordy4 = 1'b1;
    @(posedge clk); #1 ordy4 = 1'b0;
    @(negedge clk);
    checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin errors++; $display("FAIL stall_release got vld %b rdy %b exp vld 0 rdy 1", ov4, ir4); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL stall_not_queued cyc %0d got %b exp 0", c, ov4); end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] q, r;
    logic d0;
    int lat, t;
    @(negedge clk);
    iv4 = 1'b1; dd4 = 4'd14; ds4 = 4'd3;
    t = 0;
    while (!ir4 && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1 iv4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    checks++; if (ir4 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", ir4); end
    rst4_n = 1'b0;
    #1;
    checks++; if (ir4 !== 1'b1 || ov4 !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got rdy %b vld %b exp rdy 1 vld 0", ir4, ov4); end
    checks++; if (oq4 !== 4'h0 || orm4 !== 4'h0 || od4 !== 1'b0) begin errors++; $display("FAIL midrst_data got q %0d r %0d d0 %b exp 0 0 0", oq4, orm4, od4); end
    @(negedge clk); rst4_n = 1'b1;
    @(negedge clk);
    checks++; if (ir4 !== 1'b1 || ov4 !== 1'b0) begin errors++; $display("FAIL midrst_after got rdy %b vld %b exp rdy 1 vld 0", ir4, ov4); end
    op4(4'd14, 4'd3, q, r, d0, lat);
    checks++; if (q !== 4'd4 || r !== 4'd2 || d0 !== 1'b0) begin errors++; $display("FAIL midrst_redo got q %0d r %0d d0 %b exp q 4 r 2 d0 0", q, r, d0); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_latency got %0d exp 5", lat); end
  endtask

  task automatic test_back_to_back;
    int hits [$];
    int t;
    @(negedge clk);
    iv4 = 1'b1; dd4 = 4'd13; ds4 = 4'd3; ordy4 = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (ov4) begin
        hits.push_back(c);
        checks++; if (oq4 !== 4'd4 || orm4 !== 4'd1) begin errors++; $display("FAIL b2b_data cyc %0d got q %0d r %0d exp q 4 r 1", c, oq4, orm4); end
      end
    end
    iv4 = 1'b0;
    checks++; if (hits.size() < 3) begin errors++; $display("FAIL b2b_count got %0d exp >=3", hits.size()); end
    else begin
      checks++; if (hits[1] - hits[0] !== 6) begin errors++; $display("FAIL b2b_period1 got %0d exp 6", hits[1] - hits[0]); end
      checks++; if (hits[2] - hits[1] !== 6) begin errors++; $display("FAIL b2b_period2 got %0d exp 6", hits[2] - hits[1]); end
    end
    t = 0;
    while (!(ir4 && !ov4) && t < 30) begin @(negedge clk); t++; end
    ordy4 = 1'b0;
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL b2b_drain got %b exp 1", ir4); end
  endtask

  task automatic test_sweep8;
    logic [7:0] a, b, eq, er;
    logic ed0;
    int lat, elat, t, gap, stall;
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) @(negedge clk);
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if (b == 0) begin eq = 8'hFF; er = a; ed0 = 1'b1; elat = 1; end
      else begin eq = a / b; er = a % b; ed0 = 1'b0; elat = 9; end
      @(negedge clk);
      iv8 = 1'b1; dd8 = a; ds8 = b;
      t = 0;
      while (!ir8 && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #1 iv8 = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!ov8 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) @(negedge clk);
      checks++; if (lat !== elat) begin errors++; $display("FAIL sweep_latency op %0d %0d/%0d got %0d exp %0d", i, a, b, lat, elat); end
      checks++; if (oq8 !== eq) begin errors++; $display("FAIL sweep_quot op %0d %0d/%0d got %0d exp %0d", i, a, b, oq8, eq); end
      checks++; if (orm8 !== er) begin errors++; $display("FAIL sweep_rem op %0d %0d/%0d got %0d exp %0d", i, a, b, orm8, er); end
      checks++; if (od8 !== ed0) begin errors++; $display("FAIL sweep_div0 op %0d %0d/%0d got %b exp %b", i, a, b, od8, ed0); end
      ordy8 = 1'b1;
      @(posedge clk); #1 ordy8 = 1'b0;
      @(negedge clk);
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL sweep_dup op %0d got vld %b exp 0", i, ov8); end
    end
  endtask

  initial begin
    rst4_n = 1'b0; rst8_n = 1'b0;
    iv4 = 1'b0; dd4 = '0; ds4 = '0; ordy4 = 1'b0;
    iv8 = 1'b0; dd8 = '0; ds8 = '0; ordy8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst4_n = 1'b1; rst8_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_directed;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    test_sweep8;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
